// File: rtl/clb_param.sv
// Parametrised configurable logic block: N slices of K-input LUTs.
// Serial shadow config, atomic commit, optional registered outputs.
module clb_param #(
  parameter int K      = 4,
  parameter int N      = 2,
  parameter int NUM_IN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              shift_i,
  output logic              shift_o,
  input  logic              cfg_load,
  output logic              cfg_valid,
  output logic              cfg_err,
  input  logic [NUM_IN-1:0] din,
  input  logic              ce,
  output logic [N-1:0]      dout
);

  localparam int SEL_W   = $clog2(NUM_IN);
  localparam int TT_W    = 2 ** K;
  localparam int RS_OFF  = TT_W + K * SEL_W;
  localparam int IN_OFF  = RS_OFF + 1;
  localparam int CE_OFF  = RS_OFF + 2;
  localparam int SLICE_W = TT_W + K * SEL_W + 3;
  localparam int CFG_LEN = N * SLICE_W;
  localparam int CNT_W   = $clog2(CFG_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_LEN + 1);

  logic [CFG_LEN-1:0] shadow;
  logic [CFG_LEN-1:0] active;
  logic [CNT_W-1:0]   cnt;
  logic [N-1:0]       ff;
  logic [N-1:0]       lut;
  logic [N-1:0]       reg_sel;
  logic [N-1:0]       ce_en;
  logic [N-1:0]       ff_en;
  logic [N-1:0]       init_new;
  logic [N-1:0]       unused_init;
  logic               cfg_commit;

  // Route one general input; out-of-range selects read as 0.
  function automatic logic pick(
    input logic [SEL_W-1:0]  sel,
    input logic [NUM_IN-1:0] d
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) r = d[i];
    end
    return r;
  endfunction

  assign shift_o    = shadow[0];
  assign cfg_commit = cfg_load && (cnt == CNT_FULL);

  for (genvar s = 0; s < N; s++) begin : g_slice
    logic [SLICE_W-1:0] fa;
    logic [TT_W-1:0]    truth;
    logic [K-1:0]       idx;

    assign fa    = active[s*SLICE_W +: SLICE_W];
    assign truth = fa[TT_W-1:0];

    for (genvar j = 0; j < K; j++) begin : g_in
      assign idx[j] = pick(fa[TT_W + j*SEL_W +: SEL_W], din);
    end

    assign lut[s]         = truth[idx];
    assign reg_sel[s]     = fa[RS_OFF];
    assign unused_init[s] = fa[IN_OFF];
    assign ce_en[s]       = fa[CE_OFF];
    assign init_new[s]    = shadow[s*SLICE_W + IN_OFF];
  end

  assign ff_en = ~ce_en | {N{ce}};

  assign dout = cfg_valid
              ? ((reg_sel & ff) | (~reg_sel & lut))
              : '0;

  // Serial shadow chain and saturating bit counter; load wins over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (cfg_load) begin
      cnt <= '0;
    end else if (shift_en) begin
      shadow <= {shift_i, shadow[CFG_LEN-1:1]};
      if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

  // Commit shadow to active only on an exact-length bitstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (cfg_load) begin
      if (cnt == CNT_FULL) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Slice flops: init on commit, else track LUT when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else if (cfg_commit) begin
      ff <= init_new;
    end else if (cfg_valid && !cfg_load) begin
      ff <= (lut & ff_en) | (ff & ~ff_en);
    end
  end

endmodule

// File: tb/tb_clb_param.sv
// Self-checking bench for clb_param (K=4, N=2, NUM_IN=4).
// Randomised stimulus against a bit-queue behavioural model.
module tb_clb_param;

  localparam int K      = 4;
  localparam int N      = 2;
  localparam int NUM_IN = 4;
  localparam int SW     = 27;
  localparam int CL     = 54;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         shift_en = 1'b0;
  logic         shift_i = 1'b0;
  logic         shift_o;
  logic         cfg_load = 1'b0;
  logic         cfg_valid;
  logic         cfg_err;
  logic [3:0]   din = 4'h0;
  logic         ce = 1'b0;
  logic [1:0]   dout;

  int n_checks = 0;
  int n_fail   = 0;

  clb_param #(.K(K), .N(N), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .rst_n(rst_n),
    .shift_en(shift_en), .shift_i(shift_i), .shift_o(shift_o),
    .cfg_load(cfg_load), .cfg_valid(cfg_valid), .cfg_err(cfg_err),
    .din(din), .ce(ce), .dout(dout)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit sh[$];
  bit act[CL];
  bit m_ff[N];
  bit m_valid;
  bit m_err;
  int m_cnt;

  function automatic int fld(int lo, int w);
    int v = 0;
    for (int i = 0; i < w; i++) if (act[lo+i]) v += (1 << i);
    return v;
  endfunction

  function automatic bit m_lut(int s);
    int base = s * SW;
    int truth = fld(base, 16);
    int idx = 0;
    for (int j = 0; j < K; j++) begin
      int sel = fld(base + 16 + 2*j, 2);
      if (sel < NUM_IN && din[sel] === 1'b1) idx += (1 << j);
    end
    return ((truth >> idx) & 1) != 0;
  endfunction

  function automatic logic [1:0] m_dout();
    logic [1:0] r = 2'b00;
    for (int s = 0; s < N; s++) begin
      if (m_valid) r[s] = act[s*SW+24] ? m_ff[s] : m_lut(s);
    end
    return r;
  endfunction

  function automatic void model_reset();
    sh.delete();
    for (int i = 0; i < CL; i++) sh.push_back(1'b0);
    for (int i = 0; i < CL; i++) act[i] = 1'b0;
    for (int s = 0; s < N; s++) m_ff[s] = 1'b0;
    m_valid = 0;
    m_err = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_step();
    if (cfg_load) begin
      if (m_cnt == CL) begin
        for (int i = 0; i < CL; i++) act[i] = sh[i];
        for (int s = 0; s < N; s++) m_ff[s] = sh[s*SW+25];
        m_valid = 1;
        m_err = 0;
      end else begin
        m_err = 1;
      end
      m_cnt = 0;
    end else begin
      if (m_valid) begin
        for (int s = 0; s < N; s++)
          if (!act[s*SW+26] || ce) m_ff[s] = m_lut(s);
      end
      if (shift_en) begin
        sh.push_back(shift_i);
        void'(sh.pop_front());
        if (m_cnt < CL + 1) m_cnt++;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- stimulus helpers ----------------
  function automatic bit [53:0] mk(
    bit [15:0] t0, bit r0, bit i0, bit c0,
    bit [15:0] t1, bit r1, bit i1, bit c1
  );
    return {c1, i1, r1, 8'hE4, t1, c0, i0, r0, 8'hE4, t0};
  endfunction

  function automatic bit [53:0] rnd54();
    bit [53:0] r;
    r[31:0]  = $urandom;
    r[53:32] = 22'($urandom);
    return r;
  endfunction

  task automatic shift_bits(input bit [53:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      shift_i  = v[i];
      shift_en = 1'b1;
      @(posedge clk); #1;
    end
    shift_en = 1'b0;
    shift_i  = 1'b0;
  endtask

  task automatic do_load();
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  function automatic logic [1:0] and_xor(logic [3:0] d);
    return {^d, &d};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    #1;
    n_checks++;
    if (dout !== 2'b00) begin
      n_fail++; $display("FAIL reset_dout got=%b want=00", dout);
    end
    n_checks++;
    if (cfg_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b want=0", cfg_valid);
    end
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got=%b want=0", cfg_err);
    end
    n_checks++;
    if (shift_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_shift_o got=%b want=0", shift_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_and_xor();
    shift_bits(mk(16'h8000, 0, 0, 0, 16'h6996, 0, 0, 0), CL);
    do_load();
    n_checks++;
    if (cfg_valid !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL andxor_status valid=%b err=%b want 1/0", cfg_valid, cfg_err);
    end
    for (int d = 0; d < 16; d++) begin
      @(posedge clk); #1;
      din = 4'(d);
      #1;
      n_checks++;
      if (dout !== and_xor(din)) begin
        n_fail++;
        $display("FAIL andxor_sweep din=%h got=%b want=%b", din, dout, and_xor(din));
      end
      n_checks++;
      if (dout !== m_dout()) begin
        n_fail++;
        $display("FAIL andxor_model din=%h got=%b want=%b", din, dout, m_dout());
      end
    end
  endtask

  task automatic test_short_load();
    shift_bits(rnd54(), CL - 1);
    do_load();
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL short_status err=%b valid=%b want 1/1", cfg_err, cfg_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      din = 4'($urandom);
      #1;
      n_checks++;
      if (dout !== and_xor(din)) begin
        n_fail++;
        $display("FAIL short_keep din=%h got=%b want=%b", din, dout, and_xor(din));
      end
    end
    shift_bits(mk(16'h8000, 0, 0, 0, 16'h6996, 0, 0, 0), CL);
    do_load();
    n_checks++;
    if (cfg_err !== 1'b0 || cfg_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL short_recover err=%b valid=%b want 0/1", cfg_err, cfg_valid);
    end
  endtask

  task automatic test_registered();
    din = 4'h0;
    ce  = 1'b0;
    shift_bits(mk(16'hAAAA, 1, 1, 1, 16'h6996, 0, 0, 0), CL);
    do_load();
    n_checks++;
    if (dout !== 2'b01) begin
      n_fail++; $display("FAIL reg_init got=%b want=01", dout);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dout[0] !== 1'b1) begin
        n_fail++; $display("FAIL reg_hold edge=%0d got=%b want=1", i, dout[0]);
      end
    end
    ce = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dout[0] !== 1'b0) begin
      n_fail++; $display("FAIL reg_ce got=%b want=0", dout[0]);
    end
    din = 4'h1;
    #1;
    n_checks++;
    if (dout !== 2'b10) begin
      n_fail++; $display("FAIL reg_no_comb got=%b want=10", dout);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dout !== 2'b11) begin
      n_fail++; $display("FAIL reg_follow got=%b want=11", dout);
    end
    ce = 1'b0;
  endtask

  task automatic test_shadow();
    bit [53:0] p;
    bit [53:0] q;
    bit [53:0] c;
    shift_bits(mk(16'h8000, 0, 0, 0, 16'h6996, 0, 0, 0), CL);
    do_load();
    p = rnd54();
    for (int i = 0; i < CL; i++) begin
      din = 4'($urandom);
      shift_i = p[i];
      shift_en = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (dout !== and_xor(din)) begin
        n_fail++;
        $display("FAIL shadow_live i=%0d got=%b want=%b", i, dout, and_xor(din));
      end
    end
    shift_en = 1'b0;
    n_checks++;
    if (shift_o !== p[0]) begin
      n_fail++; $display("FAIL shadow_out0 got=%b want=%b", shift_o, p[0]);
    end
    q = rnd54();
    for (int i = 0; i < CL; i++) begin
      shift_i = q[i];
      shift_en = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (shift_o !== ((i < CL - 1) ? p[i+1] : q[0])) begin
        n_fail++;
        $display("FAIL shadow_chain i=%0d got=%b want=%b", i, shift_o,
                 (i < CL - 1) ? p[i+1] : q[0]);
      end
    end
    shift_i = ~q[1];
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    shift_en = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || shift_o !== q[0]) begin
      n_fail++;
      $display("FAIL sat_load err=%b shift_o=%b want 1/%b", cfg_err, shift_o, q[0]);
    end
    c = mk(16'h0001, 0, 0, 0, 16'hFFFE, 0, 0, 0);
    shift_bits(c, CL);
    shift_i = 1'b1;
    shift_en = 1'b1;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    shift_en = 1'b0;
    n_checks++;
    if (cfg_valid !== 1'b1 || cfg_err !== 1'b0 || shift_o !== c[0]) begin
      n_fail++;
      $display("FAIL prio_load valid=%b err=%b shift_o=%b want 1/0/%b",
               cfg_valid, cfg_err, shift_o, c[0]);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      din = (i == 0) ? 4'h0 : 4'($urandom);
      #1;
      n_checks++;
      if (dout !== {din != 4'h0, din == 4'h0}) begin
        n_fail++;
        $display("FAIL nor_or din=%h got=%b want=%b", din, dout,
                 {din != 4'h0, din == 4'h0});
      end
    end
  endtask

  task automatic test_random_cfg();
    for (int r = 0; r < 4; r++) begin
      shift_bits(rnd54(), CL);
      do_load();
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        din = 4'($urandom);
        ce  = 1'($urandom);
        #1;
        n_checks++;
        if (dout !== m_dout()) begin
          n_fail++;
          $display("FAIL rand_cfg r=%0d i=%0d din=%h got=%b want=%b",
                   r, i, din, dout, m_dout());
        end
      end
    end
    ce = 1'b0;
  endtask

  task automatic test_reset_mid();
    shift_bits(rnd54(), 20);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dout !== 2'b00 || cfg_valid !== 1'b0 || cfg_err !== 1'b0 || shift_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset dout=%b valid=%b err=%b so=%b want 00/0/0/0",
               dout, cfg_valid, cfg_err, shift_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load();
    n_checks++;
    if (cfg_valid !== 1'b0 || cfg_err !== 1'b1 || dout !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_noload valid=%b err=%b dout=%b want 0/1/00",
               cfg_valid, cfg_err, dout);
    end
    shift_bits(mk(16'h8000, 0, 0, 0, 16'h6996, 0, 0, 0), CL);
    do_load();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      din = 4'($urandom);
      #1;
      n_checks++;
      if (dout !== and_xor(din)) begin
        n_fail++;
        $display("FAIL mid_restore din=%h got=%b want=%b", din, dout, and_xor(din));
      end
    end
  endtask

  initial begin
    test_reset();
    test_and_xor();
    test_short_load();
    test_registered();
    test_shadow();
    test_random_cfg();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
